// File: rtl/opl3_reg_write_queue_if.sv
//------------------------------------------------------------------------------
// Module      : opl3_reg_write_queue_if
// Description : Host-side register write channel (valid/ready with bank,
//               address and data) feeding the OPL3 register write queue.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface opl3_reg_write_queue_if #(
    parameter int BANK_WIDTH = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [BANK_WIDTH-1:0] wr_bank;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output wr_valid, wr_bank, wr_addr, wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_bank, wr_addr, wr_data,
        output wr_ready
    );
endinterface

`default_nettype wire

// File: rtl/opl3_reg_write_queue.sv
//------------------------------------------------------------------------------
// Module      : opl3_reg_write_queue
// Description : FIFO of host register writes drained into the banked register
//               memory when the sample pipeline allows; sequences full clears.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module opl3_reg_write_queue #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int NUM_BANKS  = 2,
    parameter int FIFO_DEPTH = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int BANK_WIDTH = $clog2(NUM_BANKS),
    localparam int LVL_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    opl3_reg_write_queue_if.slave      wr,
    input  wire logic                  drain_en,
    input  wire logic                  clear_req,
    output logic                       wea,
    output logic [BANK_WIDTH-1:0]      banka,
    output logic [ADDR_WIDTH-1:0]      addra,
    output logic [DATA_WIDTH-1:0]      dia,
    output logic                       reset_mem,
    input  wire logic                  reset_mem_done_pulse,
    output logic [LVL_WIDTH-1:0]       level,
    output logic                       busy
);

    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_ENTRY_W = BANK_WIDTH + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [LVL_WIDTH-1:0] c_FULL    = LVL_WIDTH'(FIFO_DEPTH);
    localparam logic [LVL_WIDTH-1:0] c_LVL_ONE = LVL_WIDTH'(1);
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_CLEAR_ISSUE = 2'd1,
        ST_CLEAR_WAIT  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [LVL_WIDTH-1:0]   r_level;
    logic                   w_run;
    logic                   w_clear_start;
    logic                   w_ready;
    logic                   w_push;
    logic                   w_pop;
    logic [c_ENTRY_W-1:0]   w_head;

    // A clearing cycle blocks both push and pop so nothing slips past the flush.
    assign w_run         = (r_state == ST_RUN);
    assign w_clear_start = w_run && clear_req;
    assign w_ready       = w_run && (r_level != c_FULL) && !clear_req;
    assign w_push        = wr.wr_valid && w_ready;
    assign w_pop         = w_run && !clear_req && drain_en && (r_level != '0);
    assign w_head        = r_mem[r_rd_ptr];

    assign wr.wr_ready = w_ready;
    assign level       = r_level;
    assign busy        = !w_run || (r_level != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN:         if (clear_req) w_state_nxt = ST_CLEAR_ISSUE;
            ST_CLEAR_ISSUE: w_state_nxt = ST_CLEAR_WAIT;
            ST_CLEAR_WAIT:  if (reset_mem_done_pulse) w_state_nxt = ST_RUN;
            default:        w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {wr.wr_bank, wr.wr_addr, wr.wr_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_clear_start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            if (w_push && !w_pop) begin
                r_level <= r_level + c_LVL_ONE;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_LVL_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wea       <= 1'b0;
            reset_mem <= 1'b0;
            banka     <= '0;
            addra     <= '0;
            dia       <= '0;
        end else begin
            wea       <= w_pop;
            reset_mem <= w_clear_start;
            if (w_pop) begin
                {banka, addra, dia} <= w_head;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_opl3_reg_write_queue.sv
//------------------------------------------------------------------------------
// Module      : tb_opl3_reg_write_queue
// Description : Scoreboard bench for opl3_reg_write_queue; directed vectors.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_opl3_reg_write_queue;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       drain_en = 1'b0;
    logic       clear_req = 1'b0;
    logic       reset_mem_done_pulse = 1'b0;
    logic       wea;
    logic       reset_mem;
    logic       busy;
    logic [0:0] banka;
    logic [7:0] addra;
    logic [7:0] dia;
    logic [4:0] level;

    int n_checks = 0;
    int n_fail   = 0;
    logic [16:0] exp_q [$];

    opl3_reg_write_queue_if #(.BANK_WIDTH(1), .ADDR_WIDTH(8), .DATA_WIDTH(8)) wr_if ();

    opl3_reg_write_queue #(
        .DATA_WIDTH(8),
        .DEPTH     (256),
        .NUM_BANKS (2),
        .FIFO_DEPTH(16)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .wr                  (wr_if.slave),
        .drain_en            (drain_en),
        .clear_req           (clear_req),
        .wea                 (wea),
        .banka               (banka),
        .addra               (addra),
        .dia                 (dia),
        .reset_mem           (reset_mem),
        .reset_mem_done_pulse(reset_mem_done_pulse),
        .level               (level),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus, applied on the falling edge.
    task automatic drive(input bit valid, input logic [0:0] bank, input logic [7:0] addr,
                         input logic [7:0] data, input bit drain, input bit clr, input bit acc);
        @(negedge clk);
        wr_if.wr_valid = valid;
        wr_if.wr_bank  = bank;
        wr_if.wr_addr  = addr;
        wr_if.wr_data  = data;
        drain_en       = drain;
        clear_req      = clr;
        #1;
        if (valid) begin
            check("wr_ready", 32'(wr_if.wr_ready), 32'(acc));
            if (acc) exp_q.push_back({bank, addr, data});
        end
    endtask

    task automatic idle(input bit drain);
        drive(1'b0, 1'b0, 8'h00, 8'h00, drain, 1'b0, 1'b0);
    endtask

    // Monitor: every memory write must match the oldest accepted host write.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (!reset && wea) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_wea: got write addr=0x%0h dia=0x%0h, expected none", addra, dia);
                end else begin
                    e = exp_q.pop_front();
                    check("mem_write", 32'({banka, addra, dia}), 32'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int rm_cnt;
        int rdy_cnt;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_bank  = 1'b0;
        wr_if.wr_addr  = 8'h00;
        wr_if.wr_data  = 8'h00;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_wea", 32'(wea), 0);
        check("rst_reset_mem", 32'(reset_mem), 0);
        check("rst_bank_addr_data", 32'({banka, addra, dia}), 0);
        check("rst_level", 32'(level), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_ready", 32'(wr_if.wr_ready), 1);

        // Basic drain
        drive(1'b1, 1'b1, 8'h20, 8'hA5, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        check("basic_level_1", 32'(level), 1);
        check("basic_busy", 32'(busy), 1);
        idle(1'b0);
        check("basic_wea_high", 32'(wea), 1);
        check("basic_level_0", 32'(level), 0);
        idle(1'b0);
        check("basic_wea_one_cycle", 32'(wea), 0);

        // Full / backpressure
        for (int i = 0; i < 16; i++)
            drive(1'b1, 1'(i), 8'(8'h40 + i), 8'(i), 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 8'hEE, 8'hFF, 1'b0, 1'b0, 1'b0);
        check("full_level_16", 32'(level), 16);
        idle(1'b1);
        check("full_17th_rejected", 32'(level), 16);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            idle(1'b1);
            if (wea) cnt++;
        end
        check("full_consecutive_writes", 32'(cnt), 16);
        idle(1'b0);
        check("full_wea_done", 32'(wea), 0);
        check("full_level_0", 32'(level), 0);

        // Simultaneous push/pop across pointer wrap
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b0, 8'(8'h80 + i), 8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'(i), 8'(8'h90 + i), 8'(8'h20 + i), 1'b1, 1'b0, 1'b1);
            check("simul_level_4", 32'(level), 4);
        end
        idle(1'b0);
        check("simul_level_after", 32'(level), 4);
        repeat (4) idle(1'b1);
        idle(1'b0);
        check("simul_drained", 32'(level), 0);

        // Clear with pending writes
        for (int i = 0; i < 5; i++)
            drive(1'b1, 1'b0, 8'(8'hC0 + i), 8'(8'h30 + i), 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        check("clear_wr_ready_low", 32'(wr_if.wr_ready), 0);
        exp_q.delete();
        idle(1'b1);
        check("clear_reset_mem", 32'(reset_mem), 1);
        check("clear_level_0", 32'(level), 0);
        check("clear_no_wea", 32'(wea), 0);
        check("clear_issue_wr_ready", 32'(wr_if.wr_ready), 0);
        check("clear_busy", 32'(busy), 1);
        rm_cnt = 0;
        rdy_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            if (k == 100) drive(1'b1, 1'b0, 8'h11, 8'h22, 1'b1, 1'b1, 1'b0);
            else          idle(1'b1);
            if (reset_mem) rm_cnt++;
            if (wr_if.wr_ready) rdy_cnt++;
        end
        check("clear_single_reset_mem", 32'(rm_cnt), 0);
        check("clear_wait_wr_ready", 32'(rdy_cnt), 0);
        idle(1'b0);
        reset_mem_done_pulse = 1'b1;
        #1;
        check("clear_done_same_cycle", 32'(wr_if.wr_ready), 0);
        idle(1'b0);
        reset_mem_done_pulse = 1'b0;
        #1;
        check("clear_done_wr_ready", 32'(wr_if.wr_ready), 1);
        check("clear_done_busy", 32'(busy), 0);

        // Stray done pulse in RUN
        drive(1'b1, 1'b1, 8'h55, 8'h66, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 8'h56, 8'h67, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        reset_mem_done_pulse = 1'b1;
        idle(1'b0);
        reset_mem_done_pulse = 1'b0;
        check("stray_level", 32'(level), 2);
        check("stray_reset_mem", 32'(reset_mem), 0);
        check("stray_wr_ready", 32'(wr_if.wr_ready), 1);
        repeat (2) idle(1'b1);
        idle(1'b0);
        check("stray_drained", 32'(level), 0);

        // Async reset mid-drain
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b1, 8'(8'hD0 + i), 8'(8'hE0 + i), 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        check("drain_wea_before_reset", 32'(wea), 1);
        reset = 1'b1;
        #1;
        check("arst_drain_wea", 32'(wea), 0);
        check("arst_drain_level", 32'(level), 0);
        check("arst_drain_outputs", 32'({banka, addra, dia}), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_drain_wr_ready", 32'(wr_if.wr_ready), 1);

        // Async reset mid-clear
        drive(1'b1, 1'b0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        exp_q.delete();
        idle(1'b0);
        repeat (3) idle(1'b0);
        check("midclear_busy", 32'(busy), 1);
        check("midclear_wr_ready", 32'(wr_if.wr_ready), 0);
        reset = 1'b1;
        #1;
        check("arst_clear_reset_mem", 32'(reset_mem), 0);
        check("arst_clear_wea", 32'(wea), 0);
        check("arst_clear_level", 32'(level), 0);
        check("arst_clear_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_clear_wr_ready", 32'(wr_if.wr_ready), 1);
        drive(1'b1, 1'b1, 8'h77, 8'h88, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b0);
        check("post_reset_level", 32'(level), 0);

        repeat (3) idle(1'b0);
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/opl3_reg_write_queue.md
# opl3_reg_write_queue

Buffers host-side OPL3 register writes (bank, address, data) in a small FIFO and drains them into the banked operator/channel register memory at the rate the sample pipeline permits. Sits directly upstream of the banked reset-capable register memory: it drives the memory's write port (`wea`, `banka`, `addra`, `dia`) and its `reset_mem` request, and consumes `reset_mem_done_pulse`. It also sequences a full register clear. Host writes are held off while the clear runs, and any queued writes are discarded.

## Interface
- `DATA_WIDTH`, default 8: register data width.
- `DEPTH`, default 256: entries per memory bank (power of 2); `ADDR_WIDTH = $clog2(DEPTH)`.
- `NUM_BANKS`, default 2: memory bank count; `BANK_WIDTH = $clog2(NUM_BANKS)`.
- `FIFO_DEPTH`, default 16: queue entries (power of 2, ≥2).
- `clk` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `wr_valid` in 1: host write request.
- `wr_ready` out 1: queue accepts a write this cycle.
- `wr_bank` in BANK_WIDTH: target bank.
- `wr_addr` in ADDR_WIDTH: target register address.
- `wr_data` in DATA_WIDTH: register value.
- `drain_en` in 1: the sample pipeline allows a memory write this cycle.
- `clear_req` in 1: request a full register clear (level sampled per cycle).
- `wea` out 1: memory write enable (registered).
- `banka` out BANK_WIDTH: memory write bank (registered).
- `addra` out ADDR_WIDTH: memory write address (registered).
- `dia` out DATA_WIDTH: memory write data (registered).
- `reset_mem` out 1: one-cycle clear request to the memory (registered).
- `reset_mem_done_pulse` in 1: the memory has finished clearing.
- `level` out $clog2(FIFO_DEPTH)+1: current queue occupancy.
- `busy` out 1: high when the state is not RUN or `level != 0`.

## Operation
- **States:** RUN, CLEAR_ISSUE, CLEAR_WAIT. Reset enters RUN.
- **RUN:**
  - Push when `wr_valid && wr_ready`.
  - Pop when `drain_en && level != 0`.
  - Push and pop may occur in the same cycle; `level` is then unchanged.
- **`wr_ready` rule:** `wr_ready = (state == RUN) && (level != FIFO_DEPTH) && !clear_req`.
  - It does not depend on a same-cycle pop, so a full queue accepts nothing even if it pops that cycle.
- **Pop output:** a pop registers the head entry onto `banka/addra/dia` with `wea = 1` for exactly one cycle.
  - In non-pop cycles `wea = 0`.
  - `banka/addra/dia` hold their last value.
- **Clear from RUN:** `clear_req = 1` in RUN moves to CLEAR_ISSUE.
  - That cycle does no push and no pop.
  - The FIFO is flushed: pointers and `level` go to 0 next cycle.
- **CLEAR_ISSUE:** `reset_mem = 1` for one cycle, `wea = 0`, then move to CLEAR_WAIT.
- **CLEAR_WAIT:** `wea = 0` and `wr_ready = 0`.
  - On `reset_mem_done_pulse = 1`, return to RUN.
  - `clear_req` is ignored in CLEAR_ISSUE and CLEAR_WAIT; it is not queued.
- **Stray done pulse:** `reset_mem_done_pulse` arriving in RUN or CLEAR_ISSUE is ignored.
- **Pointer arithmetic:**
  - Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - `level` is one bit wider so it can represent full.
- **Ordering:** writes reach memory in acceptance order. There is no coalescing of writes to the same address.
- **Async reset:** asserting `reset` mid-drain or mid-clear immediately forces RUN and an empty queue. All outputs go to their reset values.

## Timing
- **Reset values:**
  - `wea = 0`, `reset_mem = 0`, `banka = 0`, `addra = 0`, `dia = 0`, `level = 0`, `busy = 0`.
  - `wr_ready = 1` once `reset` deasserts, provided `clear_req = 0`.
- **Push latency:** a push in cycle N makes the entry poppable in cycle N+1, not the same cycle (no fall-through).
- **Write latency:** a pop in cycle N gives `wea = 1` in cycle N+1. With `drain_en` held high, the write rate is one per cycle.
- **Clear sequence:**
  - `clear_req` sampled in cycle N → CLEAR_ISSUE in N+1, with `reset_mem = 1` during N+1.
  - CLEAR_WAIT from N+2.
  - `reset_mem_done_pulse` in cycle M → RUN in M+1; `wr_ready` can be 1 from M+1.
- **Level update:** `level` updates the cycle after a push or pop.

## Test plan
- **Basic drain:** reset; push (bank 1, addr 0x20, data 0xA5) with `drain_en = 0`; `level = 1`. Raise `drain_en` → next cycle `wea = 1`, `banka = 1`, `addra = 0x20`, `dia = 0xA5`; `level = 0`; `wea` back to 0 after one cycle.
- **Full / backpressure:** with `drain_en = 0`, push 16 entries with data 0..15 → `wr_ready = 0`, `level = 16`. A 17th `wr_valid` is not accepted. Raise `drain_en` → `wea` pulses for 16 consecutive cycles with `dia` = 0..15 in order.
- **Simultaneous push/pop:** hold `level = 4`, assert `wr_valid` and `drain_en` together for 20 cycles → `level` stays 4. Data order is preserved across pointer wrap-around.
- **Clear with pending writes:** queue 5 entries, pulse `clear_req` → `reset_mem` pulses exactly once one cycle later, `level = 0`, no `wea` for the discarded entries, `wr_ready = 0`. Drive `reset_mem_done_pulse` 300 cycles later → `wr_ready = 1` the next cycle.
- **Clear robustness:** a second `clear_req` during CLEAR_WAIT produces no second `reset_mem`. A `reset_mem_done_pulse` in RUN has no effect.
- **Async reset mid-clear:** assert `reset` in CLEAR_WAIT → `reset_mem = 0`, `wea = 0`, `level = 0` immediately. After release, state is RUN and `wr_ready = 1`.
